// File: rtl/mem_sync_bank_if.sv
// Request/response bundle for mem_sync_bank: independent read and write ports plus init status.
interface mem_sync_bank_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic                  rd_req;
  logic [ADDR_W-1:0]     rd_addr;
  logic [DATA_W-1:0]     rd_data;
  logic                  rd_valid;
  logic                  rd_err;
  logic                  wr_req;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W/8-1:0]   wr_be;
  logic                  wr_err;
  logic                  busy;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    input  rd_data, rd_valid, rd_err, wr_err, busy
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    output rd_data, rd_valid, rd_err, wr_err, busy
  );
endinterface

// File: rtl/mem_sync_bank.sv
// Synchronous data memory: 1-cycle registered read, byte-lane writes, range checks.
// After reset an init sequencer fills the array (zero or ramp) and holds off requests while busy.
module mem_sync_bank #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int INIT_MODE = 2,
  parameter int INIT_STEP = 10
) (
  input  logic          clk,
  input  logic          rst,
  mem_sync_bank_if.slave bus
);

  localparam int BE_W   = DATA_W / 8;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PROD_W = DATA_W + ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(DEPTH - 1);
  localparam logic [PROD_W-1:0] STEP_X   = PROD_W'(INIT_STEP);

  typedef enum logic {ST_INIT, ST_READY} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              init_we;
  logic              busy;
  logic [PROD_W-1:0] ramp;
  logic [DATA_W-1:0] init_val;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q, rd_err_q, wr_err_q;

  logic ready, rd_fire, wr_fire, rd_in, wr_in;

  assign ready   = (state_q == ST_READY);
  assign rd_fire = ready & bus.rd_req;
  assign wr_fire = ready & bus.wr_req;
  // Unsigned compare with one spare bit so DEPTH == 2**ADDR_W is representable
  assign rd_in   = {1'b0, bus.rd_addr} < DEPTH_X;
  assign wr_in   = {1'b0, bus.wr_addr} < DEPTH_X;

  always_comb begin
    ramp     = PROD_W'(cnt_q) * STEP_X;
    init_val = (INIT_MODE == 2) ? ramp[DATA_W-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (INIT_MODE != 0) ? ST_INIT : ST_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_we = 1'b0;
    busy    = 1'b0;
    case (state_q)
      ST_INIT: begin
        busy    = 1'b1;
        init_we = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_READY;
      end
    endcase
  end

  // Array is never cleared by reset so INIT_MODE 0 keeps its contents
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (init_we) begin
        mem_q[IDX_W'(cnt_q)] <= init_val;
      end else if (wr_fire && wr_in) begin
        for (int k = 0; k < BE_W; k++) begin
          if (bus.wr_be[k]) begin
            mem_q[IDX_W'(bus.wr_addr)][8*k +: 8] <= bus.wr_data[8*k +: 8];
          end
        end
      end
    end
  end

  // Read-first: this samples the array before a same-edge write lands
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_fire;
      rd_err_q   <= rd_fire & ~rd_in;
      wr_err_q   <= wr_fire & ~wr_in;
      if (rd_fire) begin
        rd_data_q <= rd_in ? mem_q[IDX_W'(bus.rd_addr)] : '0;
      end
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_err   = rd_err_q;
  assign bus.wr_err   = wr_err_q;
  assign bus.busy     = busy;

endmodule

// File: tb/tb_mem_sync_bank.sv
// Bench for mem_sync_bank: default ramp build, DEPTH=200 build and INIT_MODE=0 build,
// checked against an array model built from the fill rules and byte-lane merge.
module tb_mem_sync_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;

  mem_sync_bank_if #(.DATA_W(16), .ADDR_W(8)) ba ();
  mem_sync_bank_if #(.DATA_W(16), .ADDR_W(8)) bb ();
  mem_sync_bank_if #(.DATA_W(16), .ADDR_W(8)) bc ();

  mem_sync_bank #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .INIT_MODE(2), .INIT_STEP(10))
    dut_a (.clk(clk), .rst(rst_a), .bus(ba.slave));
  mem_sync_bank #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .INIT_MODE(2), .INIT_STEP(10))
    dut_b (.clk(clk), .rst(rst_b), .bus(bb.slave));
  mem_sync_bank #(.DATA_W(16), .ADDR_W(8), .DEPTH(16), .INIT_MODE(0), .INIT_STEP(10))
    dut_c (.clk(clk), .rst(rst_c), .bus(bc.slave));

  int checks = 0;
  int errors = 0;
  logic [15:0] model_a [256];
  logic [15:0] last_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] be);
    return {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
  endfunction

  task automatic init_model_a();
    for (int i = 0; i < 256; i++) model_a[i] = 16'(i * 10);
  endtask

  task automatic idle_a();
    ba.rd_req = 1'b0;
    ba.wr_req = 1'b0;
    ba.wr_be  = 2'b00;
  endtask

  task automatic read_a(input logic [7:0] addr, input string tag);
    ba.rd_req  = 1'b1;
    ba.rd_addr = addr;
    tick();
    ba.rd_req = 1'b0;
    check(tag, 32'({ba.rd_valid, ba.rd_err, ba.rd_data}), 32'({1'b1, 1'b0, model_a[addr]}));
    last_a = model_a[addr];
  endtask

  task automatic write_a(input logic [7:0] addr, input logic [15:0] d, input logic [1:0] be);
    ba.wr_req  = 1'b1;
    ba.wr_addr = addr;
    ba.wr_data = d;
    ba.wr_be   = be;
    tick();
    idle_a();
    check("a_wr_noerr", 32'(ba.wr_err), 32'(0));
    model_a[addr] = merge(model_a[addr], d, be);
  endtask

  task automatic count_busy(input int which, output int n);
    logic b;
    n = 0;
    b = (which == 0) ? ba.busy : bb.busy;
    while (b === 1'b1 && n < 2000) begin
      tick();
      n++;
      b = (which == 0) ? ba.busy : bb.busy;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic saw;
    logic rr, ww;
    logic [7:0]  ra, wa;
    logic [15:0] wd, expd;
    logic [1:0]  wb;

    {ba.rd_req, ba.rd_addr, ba.wr_req, ba.wr_addr, ba.wr_data, ba.wr_be} = '0;
    {bb.rd_req, bb.rd_addr, bb.wr_req, bb.wr_addr, bb.wr_data, bb.wr_be} = '0;
    {bc.rd_req, bc.rd_addr, bc.wr_req, bc.wr_addr, bc.wr_data, bc.wr_be} = '0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    tick();
    tick();

    // ---- build A: reset state, busy length, requests ignored during fill
    check("a_reset_outs", 32'({ba.rd_valid, ba.rd_err, ba.wr_err, ba.rd_data}), 32'(0));
    check("a_reset_busy", 32'(ba.busy), 32'(1));
    rst_a = 1'b0;
    n = 0; saw = 1'b0;
    while (ba.busy === 1'b1 && n < 2000) begin
      if (n == 50 || n == 51) begin
        ba.wr_req = 1'b1; ba.wr_addr = 8'h12; ba.wr_data = 16'hBEEF; ba.wr_be = 2'b11;
        ba.rd_req = 1'b1; ba.rd_addr = 8'h12;
      end else begin
        idle_a();
      end
      tick();
      n++;
      if (ba.rd_valid !== 1'b0 || ba.wr_err !== 1'b0) saw = 1'b1;
    end
    idle_a();
    check("a_busy_cycles", 32'(n), 32'(256));
    check("a_busy_quiet", 32'(saw), 32'(0));

    init_model_a();
    read_a(8'd0,   "a_rd0");
    read_a(8'd5,   "a_rd5");
    read_a(8'd200, "a_rd200");
    read_a(8'd255, "a_rd255");
    read_a(8'h12,  "a_rd12_intact");
    tick();
    check("a_rvld_pulse_hold", 32'({ba.rd_valid, ba.rd_data}), 32'({1'b0, last_a}));

    // ---- byte lanes
    write_a(8'd3, 16'hAABB, 2'b11);
    write_a(8'd3, 16'h1122, 2'b01);
    read_a(8'd3, "a_lane_lo");
    write_a(8'd3, 16'hFFFF, 2'b00);
    read_a(8'd3, "a_lane_none");

    // ---- same-cycle read/write, read-first
    expd = model_a[7];
    ba.rd_req = 1'b1; ba.rd_addr = 8'd7;
    ba.wr_req = 1'b1; ba.wr_addr = 8'd7; ba.wr_data = 16'h5555; ba.wr_be = 2'b11;
    tick();
    idle_a();
    check("a_rw_same", 32'({ba.rd_valid, ba.rd_data}), 32'({1'b1, expd}));
    model_a[7] = merge(model_a[7], 16'h5555, 2'b11);
    read_a(8'd7, "a_rw_next");

    // ---- random back-to-back traffic
    for (int i = 0; i < 300; i++) begin
      rr = 1'($urandom_range(0, 1));
      ww = 1'($urandom_range(0, 1));
      ra = 8'($urandom_range(0, 255));
      wa = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom_range(0, 255));
      wd = 16'($urandom);
      wb = 2'($urandom_range(0, 3));
      ba.rd_req = rr; ba.rd_addr = ra;
      ba.wr_req = ww; ba.wr_addr = wa; ba.wr_data = wd; ba.wr_be = wb;
      expd = rr ? model_a[ra] : last_a;
      tick();
      check("a_rand", 32'({ba.wr_err, ba.rd_valid, ba.rd_err, ba.rd_data}),
            32'({1'b0, rr, 1'b0, expd}));
      last_a = expd;
      if (ww) model_a[wa] = merge(model_a[wa], wd, wb);
    end
    idle_a();

    // ---- reset cancels an in-flight read and a request on the reset edge
    ba.rd_req = 1'b1; ba.rd_addr = 8'd5;
    tick();
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    ba.rd_req = 1'b0;
    check("a_rst_cancel", 32'({ba.rd_valid, ba.rd_err, ba.rd_data, ba.busy}),
          32'({1'b0, 1'b0, 16'h0000, 1'b1}));
    for (int i = 0; i < 100; i++) tick();
    check("a_mid_init_busy", 32'({ba.busy, ba.rd_valid}), 32'({1'b1, 1'b0}));
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    count_busy(0, n);
    check("a_restart_cycles", 32'(n), 32'(256));
    init_model_a();
    read_a(8'd3,   "a_refill3");
    read_a(8'd7,   "a_refill7");
    read_a(8'd150, "a_refill150");

    // ---- build B: DEPTH=200, range checks
    rst_b = 1'b0;
    count_busy(1, n);
    check("b_busy_cycles", 32'(n), 32'(200));
    bb.rd_req = 1'b1; bb.rd_addr = 8'd210;
    tick();
    bb.rd_req = 1'b0;
    check("b_oob_rd210", 32'({bb.rd_valid, bb.rd_err, bb.rd_data}), 32'({1'b1, 1'b1, 16'h0000}));
    bb.rd_req = 1'b1; bb.rd_addr = 8'd200;
    tick();
    bb.rd_req = 1'b0;
    check("b_oob_rd200", 32'({bb.rd_valid, bb.rd_err, bb.rd_data}), 32'({1'b1, 1'b1, 16'h0000}));
    bb.wr_req = 1'b1; bb.wr_addr = 8'd250; bb.wr_data = 16'h1234; bb.wr_be = 2'b11;
    tick();
    bb.wr_req = 1'b0;
    check("b_wr_err", 32'({bb.wr_err, bb.rd_valid}), 32'({1'b1, 1'b0}));
    tick();
    check("b_wr_err_pulse", 32'(bb.wr_err), 32'(0));
    bb.rd_req = 1'b1; bb.rd_addr = 8'd199;
    tick();
    bb.rd_req = 1'b0;
    check("b_rd199", 32'({bb.rd_valid, bb.rd_err, bb.rd_data}), 32'({1'b1, 1'b0, 16'(199 * 10)}));

    // ---- build C: no fill, contents survive reset
    check("c_busy_in_rst", 32'(bc.busy), 32'(0));
    rst_c = 1'b0;
    bc.wr_req = 1'b1; bc.wr_addr = 8'd3; bc.wr_data = 16'h1234; bc.wr_be = 2'b11;
    tick();
    bc.wr_req = 1'b0;
    rst_c = 1'b1;
    tick();
    rst_c = 1'b0;
    check("c_after_rst", 32'({bc.busy, bc.rd_valid, bc.wr_err}), 32'(0));
    tick();
    check("c_busy_idle", 32'(bc.busy), 32'(0));
    bc.rd_req = 1'b1; bc.rd_addr = 8'd3;
    tick();
    bc.rd_req = 1'b0;
    check("c_retained", 32'({bc.rd_valid, bc.rd_err, bc.rd_data}), 32'({1'b1, 1'b0, 16'h1234}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
